mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and drives a word-wide data-memory port with a request/acknowledge handshake. It stalls upstream stages while an access is outstanding and contains the MEM/WB pipeline register that feeds write-back. Zero-wait memory behaves as a plain one-cycle pipeline register; slow memory inserts stall cycles and bubbles.

## Interface
- TIMEOUT_CYCLES, 255: wait cycles before an outstanding access is aborted; used only with MEM_STAGE_TIMEOUT_EN; legal range 1..65535.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from EX/MEM.
- ALUresult_i  in  32  effective address, or ALU result for non-memory ops.
- RS2data_i  in  32  store data.
- Rd_i  in  5  destination register.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  1 = write, 0 = read.
- dmem_addr_o  out  32  byte address; always word aligned when req = 1.
- dmem_wdata_o  out  32  write data.
- dmem_ack_i  in  1  access complete this cycle.
- dmem_rdata_i  in  32  read data; valid when ack = 1 on a read.
- stall_o  out  1  upstream stages must hold their registers this cycle.
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control.
- ALUresult_o  out  32  MEM/WB ALU result.
- MemData_o  out  32  MEM/WB load data.
- Rd_o  out  5  MEM/WB destination register.
- misalign_o  out  1  one-cycle pulse: a misaligned access was dropped.
- err_o  out  1  one-cycle pulse: an access timed out (tied 0 without the macro).

## Operation
- access = (MemRead_i | MemWrite_i) & (ALUresult_i[1:0] == 0). misacc = (MemRead_i | MemWrite_i) & (ALUresult_i[1:0] != 0).
- If MemRead_i and MemWrite_i are both set, the access is treated as a write.
- FSM has two states, IDLE and WAIT.
  - IDLE: when access = 1 and dmem_ack_i = 0, go to WAIT. Otherwise stay in IDLE.
  - WAIT: on dmem_ack_i = 1, go to IDLE. On timeout (macro only), go to IDLE.
- dmem_req_o = ~rst_i & ((IDLE & access) | WAIT). dmem_we_o = MemWrite_i. dmem_addr_o = ALUresult_i. dmem_wdata_o = RS2data_i. All are combinational from the held inputs.
- stall_o = dmem_req_o & ~dmem_ack_i & ~timeout.
- A MEM/WB update happens on each clock edge where stall_o = 0:
  - RegWrite_o, MemtoReg_o, ALUresult_o and Rd_o take their inputs.
  - MemData_o takes dmem_rdata_i when the completing access is a read; otherwise it holds its value.
- Bubble: on a clock edge where stall_o = 1, RegWrite_o and MemtoReg_o load 0. Rd_o, ALUresult_o and MemData_o hold.
- Misaligned access: no request is issued and there is no stall. MEM/WB loads with RegWrite_o = 0. misalign_o pulses for 1 cycle.
- dmem_ack_i is ignored while dmem_req_o = 0.
- Reset: state goes to IDLE and the timeout counter clears. All MEM/WB outputs, misalign_o and err_o go to 0. dmem_req_o is 0 while rst_i = 1.
- Reset during WAIT abandons the access. The memory must tolerate a request that drops without an acknowledge.

## Timing
- Zero-wait memory (ack in the request cycle): no stall; MEM/WB outputs are valid 1 cycle after the inputs.
- N wait cycles (ack N cycles after the first request cycle): stall_o is high for exactly N cycles. N bubbles enter MEM/WB, and the result appears at the edge that ends the ack cycle.
- Inputs are stable while stall_o = 1. Upstream guarantees this, so addr, we and wdata are stable for the whole request.
- Back-to-back accesses: a new request may begin in the cycle after an ack, with no idle cycle required.
- misalign_o and err_o are registered. Each pulses for exactly 1 cycle, in the cycle after the event.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - timeout = WAIT & ~dmem_ack_i & (count == TIMEOUT_CYCLES - 1).
  - On timeout: the stall is released, MEM/WB loads with RegWrite_o = 0, err_o pulses, and the FSM returns to IDLE.
  - An ack in the same cycle as the timeout condition wins, and no error is raised.
- MEM_STAGE_TIMEOUT_EN undefined: there is no counter, WAIT persists until ack, timeout = 0, and err_o = 0.

## Test plan
- Load of addr 0x10 with ack in the same cycle and rdata 0xDEADBEEF, Rd = 5 → no stall; one cycle later RegWrite_o = 1, MemtoReg_o = 1, MemData_o = 0xDEADBEEF, Rd_o = 5.
- Store of 0xCAFEF00D to 0x20 with ack after 3 wait cycles → stall_o high for 3 cycles; dmem_we_o = 1 and addr/wdata are stable throughout; 3 bubbles with RegWrite_o = 0.
- Load from 0x22 → no dmem_req_o, no stall, misalign_o pulses, RegWrite_o = 0.
- Load followed immediately by a store, both zero-wait → two consecutive requests with no gap; MEM/WB carries both results in order.
- rst_i asserted in the second WAIT cycle of a load → dmem_req_o = 0 during reset; after reset all outputs are 0 and the FSM is in IDLE.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES = 4, a load with no ack → stall for 4 cycles, then release, err_o pulses, RegWrite_o = 0. A second run with ack in the fourth cycle → normal completion and no err_o.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage: data-memory handshake, stall control, MEM/WB register
// Optional access timeout is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  Rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  Rd_o,
  output logic        misalign_o,
  output logic        err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [15:0] TLIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [0:0] state;
  logic       mem_op;
  logic       aligned;
  logic       access;
  logic       misacc;
  logic       timeout;
  logic       rd_done;

  assign mem_op  = MemRead_i | MemWrite_i;
  assign aligned = (ALUresult_i[1:0] == 2'b00);
  assign access  = mem_op & aligned;
  assign misacc  = mem_op & ~aligned;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [15:0] count;

  // Counter is held at zero in IDLE, so it is already cleared on entry to WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign timeout = (state == WAIT) & ~dmem_ack_i & (count == TLIMIT);
`else
  logic unused_cfg;
  assign unused_cfg = ^TLIMIT;
  assign timeout    = 1'b0;
`endif

  assign dmem_req_o   = ~rst_i & (((state == IDLE) & access) | (state == WAIT));
  assign dmem_we_o    = MemWrite_i;
  assign dmem_addr_o  = ALUresult_i;
  assign dmem_wdata_o = RS2data_i;
  assign stall_o      = dmem_req_o & ~dmem_ack_i & ~timeout;
  // A simultaneous read+write is a write, so only a pure read captures rdata.
  assign rd_done      = dmem_req_o & dmem_ack_i & ~MemWrite_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (access && !dmem_ack_i) state <= WAIT;
        WAIT:    if (dmem_ack_i || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ALUresult_o <= 32'd0;
      MemData_o   <= 32'd0;
      Rd_o        <= 5'd0;
      misalign_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      misalign_o <= misacc;
      err_o      <= timeout;
      if (stall_o) begin
        RegWrite_o <= 1'b0;
        MemtoReg_o <= 1'b0;
      end else begin
        RegWrite_o  <= RegWrite_i & ~misacc & ~timeout;
        MemtoReg_o  <= MemtoReg_i;
        ALUresult_o <= ALUresult_i;
        Rd_o        <= Rd_i;
        if (rd_done) MemData_o <= dmem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage (timeout cases need MEM_STAGE_TIMEOUT_EN)
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0, mem_to_reg = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] alu = '0, rs2 = '0, rdata = '0;
  logic [4:0]  rd = '0;
  logic        ack = 1'b0;
  logic        req, we, stall, rw_o, mtr_o, misalign, err;
  logic [31:0] addr, wdata, alu_o, mdata_o;
  logic [4:0]  rd_o;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [4:0]  rd;
  } wb_t;

  wb_t  sb[$];
  logic track = 1'b0;
  logic [31:0] model_mdata = '0;
  int total = 0;
  int bad = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .ALUresult_i(alu), .RS2data_i(rs2), .Rd_i(rd),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata), .stall_o(stall),
    .RegWrite_o(rw_o), .MemtoReg_o(mtr_o), .ALUresult_o(alu_o), .MemData_o(mdata_o), .Rd_o(rd_o),
    .misalign_o(misalign), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && track && !stall) begin
      wb_t exp_wb;
      #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: DUT retired an instruction, required a queued expectation");
      end else begin
        exp_wb = sb.pop_front();
        if ({rw_o, mtr_o, alu_o, mdata_o, rd_o} !== exp_wb) begin
          bad++;
          $display("FAIL wb: got rw=%b mtr=%b alu=%h mdata=%h rd=%0d, required rw=%b mtr=%b alu=%h mdata=%h rd=%0d",
                   rw_o, mtr_o, alu_o, mdata_o, rd_o,
                   exp_wb.rw, exp_wb.mtr, exp_wb.alu, exp_wb.mdata, exp_wb.rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic rdn, input logic wrn,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic ak, input logic [31:0] rdat, input logic trk);
    reg_write = rw; mem_to_reg = mtr; mem_read = rdn; mem_write = wrn;
    alu = a; rs2 = d; rd = r; ack = ak; rdata = rdat; track = trk;
  endtask

  task automatic go_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b required 0", req); end
    tick(); tick();
    total++;
    if ({rw_o, mtr_o, alu_o, mdata_o, rd_o, misalign, err} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got rw=%b mtr=%b alu=%h mdata=%h rd=%0d mis=%b err=%b required all 0",
               rw_o, mtr_o, alu_o, mdata_o, rd_o, misalign, err);
    end
    rst = 1'b0;
    go_idle();
    tick();
  endtask

  task automatic test_zero_wait_load();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1);
    model_mdata = 32'hDEADBEEF;
    sb.push_back('{1'b1, 1'b1, 32'h10, model_mdata, 5'd5});
    #1;
    total++;
    if ({req, stall} !== 2'b10) begin bad++; $display("FAIL zw_load_req: got req=%b stall=%b required req=1 stall=0", req, stall); end
    tick();
    go_idle();
    tick();
  endtask

  task automatic test_wait_store();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0, 1'b1);
    sb.push_back('{1'b0, 1'b0, 32'h20, model_mdata, 5'd0});
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({stall, req, we, addr, wdata} !== {3'b111, 32'h20, 32'hCAFEF00D}) begin
        bad++;
        $display("FAIL store_wait%0d: got stall=%b req=%b we=%b addr=%h wdata=%h required 1 1 1 00000020 cafef00d",
                 i, stall, req, we, addr, wdata);
      end
      tick();
      total++;
      if ({rw_o, mtr_o} !== 2'b00) begin bad++; $display("FAIL store_bubble%0d: got rw=%b mtr=%b required 0 0", i, rw_o, mtr_o); end
    end
    ack = 1'b1;
    #1;
    total++;
    if ({stall, req} !== 2'b01) begin bad++; $display("FAIL store_ack: got stall=%b req=%b required stall=0 req=1", stall, req); end
    tick();
    go_idle();
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd9, 1'b1, 32'h12345678, 1'b1);
    sb.push_back('{1'b0, 1'b1, 32'h22, model_mdata, 5'd9});
    #1;
    total++;
    if ({req, stall} !== 2'b00) begin bad++; $display("FAIL mis_req: got req=%b stall=%b required 0 0", req, stall); end
    tick();
    go_idle();
    total++;
    if (misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b required 1", misalign); end
    tick();
    total++;
    if (misalign !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b required 0", misalign); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 1'b1, 32'h11112222, 1'b1);
    model_mdata = 32'h11112222;
    sb.push_back('{1'b1, 1'b1, 32'h40, model_mdata, 5'd7});
    #1;
    total++;
    if ({req, we, stall} !== 3'b100) begin bad++; $display("FAIL b2b_load: got req=%b we=%b stall=%b required 1 0 0", req, we, stall); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h55AA55AA, 5'd0, 1'b1, 32'h99999999, 1'b1);
    sb.push_back('{1'b0, 1'b0, 32'h44, model_mdata, 5'd0});
    #1;
    total++;
    if ({req, we, stall, addr} !== {3'b110, 32'h44}) begin
      bad++;
      $display("FAIL b2b_store: got req=%b we=%b stall=%b addr=%h required 1 1 0 00000044", req, we, stall, addr);
    end
    tick();
    go_idle();
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 5'd4, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL rstwait_req: got %b required 0", req); end
    tick();
    rst = 1'b0;
    go_idle();
    model_mdata = 32'h0;
    #1;
    total++;
    if ({req, stall, rw_o, mtr_o, alu_o, mdata_o, rd_o, misalign, err} !== '0) begin
      bad++;
      $display("FAIL rstwait_outs: got req=%b stall=%b rw=%b mtr=%b alu=%h mdata=%h rd=%0d required all 0",
               req, stall, rw_o, mtr_o, alu_o, mdata_o, rd_o);
    end
    tick();
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 5'd6, 1'b0, 32'h0, 1'b1);
    sb.push_back('{1'b0, 1'b1, 32'h60, model_mdata, 5'd6});
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL to_stall%0d: got %b required 1", i, stall); end
      tick();
    end
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL to_release: got %b required 0", stall); end
    tick();
    go_idle();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b required 1", err); end
    tick();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b required 0", err); end

    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h64, 32'h0, 5'd8, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    ack = 1'b1; rdata = 32'hABCD0123;
    model_mdata = 32'hABCD0123;
    sb.push_back('{1'b1, 1'b1, 32'h64, model_mdata, 5'd8});
    tick();
    go_idle();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL to_ack_wins: got err=%b required 0", err); end
    tick();
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
`ifdef MEM_STAGE_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
      end
      begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
